// File: rtl/data_sync_arb.sv
// ---------------------------------------------------------------------------
// data_sync_arb
//   Receive-side multi-channel bus synchroniser.
//
//   Each channel's enable is passed through a STAGES-deep flop chain and then
//   edge-detected. A detected edge captures that channel's quasi-static data
//   bus. The captured word is held in a one-deep per-channel slot. A
//   round-robin arbiter merges the slots onto a single valid/ready stream.
//
//   Ports
//     clk           destination clock; every flop uses its rising edge
//     rst           asynchronous reset, active-high
//     bus_enable    unsynchronised enable (or toggle) line, one per channel
//     unsync_bus    channel data; channel c occupies [c*DATA_WIDTH +: DATA_WIDTH]
//     sync_bus      last word captured on each channel
//     enable_pulse  one-cycle pulse per channel, in the cycle after a capture
//     out_valid     merged stream word valid
//     out_ready     consumer accepts the word when out_valid & out_ready
//     out_data      merged stream data
//     out_chan      source channel of out_data
//     overrun       sticky per-channel flag: a capture was lost because the slot was full
//     overrun_clr   per-channel clear for overrun (a new loss wins over a clear)
// ---------------------------------------------------------------------------
module data_sync_arb #(
  parameter int STAGES      = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 2,
  parameter int TOGGLE_MODE = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            bus_enable,
  input  logic [CHANNELS*DATA_WIDTH-1:0] unsync_bus,
  output logic [CHANNELS*DATA_WIDTH-1:0] sync_bus,
  output logic [CHANNELS-1:0]            enable_pulse,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CW-1:0]                  out_chan,
  output logic [CHANNELS-1:0]            overrun,
  input  logic [CHANNELS-1:0]            overrun_clr
);

  logic [CHANNELS-1:0]   sync_chain [STAGES];
  logic [CHANNELS-1:0]   chain_prev;
  logic [CHANNELS-1:0]   chain_out;
  logic [CHANNELS-1:0]   event_det;
  logic [CHANNELS-1:0]   pending;
  logic [DATA_WIDTH-1:0] slot [CHANNELS];
  logic [CW-1:0]         rr_ptr;
  logic                  load_out;
  logic                  grant_found;
  logic [CW-1:0]         grant_idx;
  logic [CHANNELS-1:0]   grant_vec;
  logic [CHANNELS-1:0]   capture_lost;

  // Enable synchroniser chain plus the register that remembers the previous
  // chain output for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) sync_chain[s] <= '0;
      chain_prev <= '0;
    end else begin
      sync_chain[0] <= bus_enable;
      for (int s = 1; s < STAGES; s++) sync_chain[s] <= sync_chain[s-1];
      chain_prev <= chain_out;
    end
  end

  assign chain_out = sync_chain[STAGES-1];

  // Rising-edge detect in level mode, any-transition detect in toggle mode.
  always_comb begin
    if (TOGGLE_MODE != 0) event_det = chain_out ^ chain_prev;
    else                  event_det = chain_out & ~chain_prev;
  end

  // Round-robin search: first pending channel at or above the pointer,
  // otherwise the lowest pending channel (wrap-around).
  always_comb begin
    logic          found_hi;
    logic          found_lo;
    logic [CW-1:0] idx_hi;
    logic [CW-1:0] idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (pending[c] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = CW'(c);
      end
      if (pending[c] && !found_hi && (c >= int'(rr_ptr))) begin
        found_hi = 1'b1;
        idx_hi   = CW'(c);
      end
    end
    grant_found = found_hi | found_lo;
    grant_idx   = found_hi ? idx_hi : idx_lo;
  end

  // The output register can take a new word whenever it is empty or its
  // current word is being accepted this cycle.
  assign load_out = !out_valid || out_ready;

  // A slot counts as free for a new capture if it is being granted out on
  // the same edge; only a capture into a slot that stays full is lost.
  always_comb begin
    grant_vec    = '0;
    capture_lost = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      grant_vec[c]    = load_out && grant_found && (grant_idx == CW'(c));
      capture_lost[c] = event_det[c] && pending[c] && !grant_vec[c];
    end
  end

  // Per-channel capture, pulse, slot and overrun bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_bus     <= '0;
      enable_pulse <= '0;
      pending      <= '0;
      overrun      <= '0;
      for (int c = 0; c < CHANNELS; c++) slot[c] <= '0;
    end else begin
      enable_pulse <= event_det;
      for (int c = 0; c < CHANNELS; c++) begin
        if (event_det[c]) begin
          sync_bus[c*DATA_WIDTH +: DATA_WIDTH] <= unsync_bus[c*DATA_WIDTH +: DATA_WIDTH];
        end
        if (event_det[c] && !capture_lost[c]) begin
          slot[c]    <= unsync_bus[c*DATA_WIDTH +: DATA_WIDTH];
          pending[c] <= 1'b1;
        end else if (grant_vec[c]) begin
          pending[c] <= 1'b0;
        end
        if (capture_lost[c])     overrun[c] <= 1'b1;
        else if (overrun_clr[c]) overrun[c] <= 1'b0;
      end
    end
  end

  // Merged output register and round-robin pointer. With nothing pending the
  // output empties when it is free to load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_out) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= slot[grant_idx];
        out_chan  <= grant_idx;
        if (grant_idx == CW'(CHANNELS-1)) rr_ptr <= '0;
        else                              rr_ptr <= grant_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
